// File: rtl/fq_pkg.sv
// Shared types and constants for the score keeper: FSM state encoding,
// score width, winner codes and a saturating increment helper.
package fq_pkg;

  localparam int unsigned SCORE_W = 4;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_BLUE = 2'b01;
  localparam logic [1:0] WIN_RED  = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/score_keeper_toggle_event_detect.sv
// Toggle-encoded event decoder: one event per input transition, either direction.
// The first edge after reset only captures the input, so a held level is never an event.
module toggle_event_detect (
  input  logic clk,
  input  logic rst,
  input  logic tog_in,
  output logic event_out
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= tog_in;
      armed_q <= 1'b1;
    end
  end

  assign event_out = armed_q & (tog_in ^ prev_q);

endmodule

// File: rtl/score_keeper.sv
// Match controller: IDLE -> SERVE -> PLAY -> (SERVE | OVER), with saturating scores.
// Define SERVE_DELAY_EN to stretch SERVE to SERVE_DELAY cycles; otherwise SERVE lasts one cycle.
module score_keeper
  import fq_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned SERVE_DELAY = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               blue_score_up,
  input  logic               red_score_up,
  output logic               game_initiated,
  output logic               game_over,
  output logic [SCORE_W-1:0] blue_score,
  output logic [SCORE_W-1:0] red_score,
  output logic [1:0]         winner
);

  if (WIN_SCORE < 1 || WIN_SCORE > 15 || SERVE_DELAY < 1) begin : g_bad_param
    $error("score_keeper: WIN_SCORE or SERVE_DELAY out of range");
  end

  localparam logic [SCORE_W-1:0] WIN_TH = SCORE_W'(WIN_SCORE);

`ifdef SERVE_DELAY_EN
  localparam int unsigned      CNT_W           = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST        = CNT_W'(SERVE_DELAY - 1);
  localparam logic             LAUNCH_AT_ENTRY = (SERVE_DELAY == 1);
  logic [CNT_W-1:0] cnt_q;
`else
  localparam logic LAUNCH_AT_ENTRY = 1'b1;
`endif

  state_e             state_q;
  logic [SCORE_W-1:0] blue_q, red_q;
  logic [SCORE_W-1:0] blue_d, red_d;
  logic [1:0]         winner_q, winner_d;
  logic               gi_q, go_q, start_prev_q;
  logic               blue_ev, red_ev, start_rise;
  logic               blue_won, red_won;

  toggle_event_detect u_blue (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (blue_score_up),
    .event_out (blue_ev)
  );

  toggle_event_detect u_red (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (red_score_up),
    .event_out (red_ev)
  );

  always_comb begin
    start_rise = start_btn & ~start_prev_q;
    blue_d     = blue_ev ? sat_inc(blue_q) : blue_q;
    red_d      = red_ev  ? sat_inc(red_q)  : red_q;
    blue_won   = (blue_d >= WIN_TH);
    red_won    = (red_d  >= WIN_TH);
    winner_d   = WIN_NONE;
    if (blue_won && red_won) winner_d = WIN_DRAW;
    else if (blue_won)       winner_d = WIN_BLUE;
    else if (red_won)        winner_d = WIN_RED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      blue_q       <= '0;
      red_q        <= '0;
      winner_q     <= WIN_NONE;
      gi_q         <= 1'b0;
      go_q         <= 1'b0;
      start_prev_q <= 1'b0;
`ifdef SERVE_DELAY_EN
      cnt_q        <= '0;
`endif
    end else begin
      start_prev_q <= start_btn;
      gi_q         <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (start_rise) begin
            blue_q   <= '0;
            red_q    <= '0;
            winner_q <= WIN_NONE;
            go_q     <= 1'b0;
            state_q  <= SERVE;
            gi_q     <= LAUNCH_AT_ENTRY;
`ifdef SERVE_DELAY_EN
            cnt_q    <= '0;
`endif
          end
        end
        SERVE: begin
`ifdef SERVE_DELAY_EN
          // The launch pulse is registered, so it is raised on the edge entering the last count.
          if (cnt_q == CNT_LAST) begin
            state_q <= PLAY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            gi_q  <= ((cnt_q + 1'b1) == CNT_LAST);
          end
`else
          state_q <= PLAY;
`endif
        end
        PLAY: begin
          if (blue_ev || red_ev) begin
            blue_q <= blue_d;
            red_q  <= red_d;
            if (blue_won || red_won) begin
              state_q  <= OVER;
              go_q     <= 1'b1;
              winner_q <= winner_d;
            end else begin
              state_q <= SERVE;
              gi_q    <= LAUNCH_AT_ENTRY;
`ifdef SERVE_DELAY_EN
              cnt_q   <= '0;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign game_initiated = gi_q;
  assign game_over      = go_q;
  assign blue_score     = blue_q;
  assign red_score      = red_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=3, SERVE_DELAY=4; serve length follows SERVE_DELAY_EN.
module tb_score_keeper;
  import fq_pkg::*;

`ifdef SERVE_DELAY_EN
  localparam int SD = 4;
`else
  localparam int SD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, start_btn, blue_up, red_up;
  logic       gi, go;
  logic [3:0] blue_s, red_s;
  logic [1:0] win;

  int tests = 0;
  int fails = 0;

  score_keeper #(.WIN_SCORE(3), .SERVE_DELAY(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_btn      (start_btn),
    .blue_score_up  (blue_up),
    .red_score_up   (red_up),
    .game_initiated (gi),
    .game_over      (go),
    .blue_score     (blue_s),
    .red_score      (red_s),
    .winner         (win)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] b, input logic [3:0] r,
                         input logic [1:0] w, input logic o);
    chk({tag, "_blue"},   8'(blue_s), 8'(b));
    chk({tag, "_red"},    8'(red_s),  8'(r));
    chk({tag, "_winner"}, 8'(win),    8'(w));
    chk({tag, "_over"},   8'(go),     8'(o));
  endtask

  // Called just after the edge that entered SERVE.
  task automatic serve_check(input string tag);
    for (int k = 0; k < SD; k++) begin
      chk({tag, "_gi"}, 8'(gi), 8'(k == SD - 1));
      tick();
    end
    chk({tag, "_gi_end"}, 8'(gi), 8'h00);
    chk({tag, "_play"}, 8'(dut.state_q), 8'(PLAY));
  endtask

  task automatic start_game(input string tag);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk({tag, "_serve"}, 8'(dut.state_q), 8'(SERVE));
    chk_out(tag, 4'd0, 4'd0, WIN_NONE, 1'b0);
    serve_check(tag);
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; blue_up = 1'b1; red_up = 1'b1;
    tick(); tick();
    chk_out("rst", 4'd0, 4'd0, WIN_NONE, 1'b0);
    chk("rst_gi", 8'(gi), 8'h00);
    chk("rst_state", 8'(dut.state_q), 8'(IDLE));

    rst = 1'b0;
    chk("rel_bev0", 8'(dut.blue_ev), 8'h00);
    tick();
    chk("rel_bev1", 8'(dut.blue_ev), 8'h00);
    chk("rel_rev1", 8'(dut.red_ev), 8'h00);
    tick();
    chk_out("rel", 4'd0, 4'd0, WIN_NONE, 1'b0);
    chk("rel_state", 8'(dut.state_q), 8'(IDLE));

    red_up = 1'b0;
    tick(); tick();
    chk("idle_red", 8'(red_s), 8'h00);
    chk("idle_state", 8'(dut.state_q), 8'(IDLE));

    // Match 1: blue wins 3-0
    start_game("m1");
    blue_up = ~blue_up;
    tick();
    chk_out("m1g1", 4'd1, 4'd0, WIN_NONE, 1'b0);
    serve_check("m1g1");

    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
    chk("play_start_ign", 8'(dut.state_q), 8'(PLAY));
    chk("play_start_gi", 8'(gi), 8'h00);

    blue_up = ~blue_up;
    tick();
    chk_out("m1g2", 4'd2, 4'd0, WIN_NONE, 1'b0);
    serve_check("m1g2");

    blue_up = ~blue_up;
    tick();
    chk_out("m1win", 4'd3, 4'd0, WIN_BLUE, 1'b1);
    chk("m1win_state", 8'(dut.state_q), 8'(OVER));
    chk("m1win_gi", 8'(gi), 8'h00);

    blue_up = ~blue_up; red_up = ~red_up;
    tick();
    blue_up = ~blue_up;
    tick(); tick();
    chk_out("over_frozen", 4'd3, 4'd0, WIN_BLUE, 1'b1);
    chk("over_gi", 8'(gi), 8'h00);

    // Match 2: 2-2 then simultaneous goals -> draw
    start_game("m2");
    blue_up = ~blue_up;
    tick();
    chk_out("m2a", 4'd1, 4'd0, WIN_NONE, 1'b0);
    serve_check("m2a");
    red_up = ~red_up;
    tick();
    chk_out("m2b", 4'd1, 4'd1, WIN_NONE, 1'b0);
    serve_check("m2b");
    blue_up = ~blue_up;
    tick();
    serve_check("m2c");
    red_up = ~red_up;
    tick();
    chk_out("m2d", 4'd2, 4'd2, WIN_NONE, 1'b0);
    serve_check("m2d");
    blue_up = ~blue_up; red_up = ~red_up;
    tick();
    chk_out("draw", 4'd3, 4'd3, WIN_DRAW, 1'b1);
    chk("draw_state", 8'(dut.state_q), 8'(OVER));

    // Match 3: abort with reset right after a goal starts a serve
    start_game("m3");
    red_up = ~red_up;
    tick();
    chk_out("m3g", 4'd0, 4'd1, WIN_NONE, 1'b0);
    rst = 1'b1;
    #1;
    chk_out("abort", 4'd0, 4'd0, WIN_NONE, 1'b0);
    chk("abort_gi", 8'(gi), 8'h00);
    for (int k = 0; k < SD + 2; k++) begin
      tick();
      chk("abort_hold_gi", 8'(gi), 8'h00);
    end
    rst = 1'b0;
    tick(); tick();
    chk("abort_state", 8'(dut.state_q), 8'(IDLE));
    red_up = ~red_up;
    tick(); tick();
    chk("idle_red2", 8'(red_s), 8'h00);
    chk("idle_gi2", 8'(gi), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
